// File: rtl/fabcfg_axil_pkg.sv
// Shared types and helpers for the fabric-configuration AXI4-Lite register file.
// Response codes, channel FSM states and the byte-strobe merge.
package fabcfg_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fabcfg_axil_regfile.sv
// AXI4-Lite slave holding NUM_REGS 32-bit configuration registers,
// exposed as a flat bus with a one-cycle update pulse per register.
module fabcfg_axil_regfile
    import fabcfg_axil_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter int          NUM_REGS           = 4,
    parameter logic [31:0] REG_RESET          = 32'h0
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_REGS*32-1:0]            cfg_regs,
    output logic [NUM_REGS-1:0]               cfg_wr_pulse
);

    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W  = ADDR_W - 2;

    logic [31:0] regs [NUM_REGS];

    wr_state_t          wr_state, wr_next;
    logic [IDX_W-1:0]   aw_idx_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;
    logic               aw_hs, w_hs, commit;
    logic [IDX_W-1:0]   commit_idx;
    logic [31:0]        commit_data;
    logic [3:0]         commit_strb;
    logic [NUM_REGS-1:0] commit_sel;

    rd_state_t          rd_state, rd_next;
    logic               ar_hs, rd_hit;
    logic [31:0]        rd_word;

    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // Commit uses the live channel for whichever half arrives last.
    always_comb begin
        wr_next     = wr_state;
        commit      = 1'b0;
        commit_idx  = aw_idx_q;
        commit_data = w_data_q;
        commit_strb = w_strb_q;
        unique case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    commit_idx  = s00_axi_awaddr[ADDR_W-1:2];
                    commit_data = s00_axi_wdata;
                    commit_strb = s00_axi_wstrb;
                    wr_next     = W_RESP;
                end else if (aw_hs) begin
                    wr_next = W_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit      = 1'b1;
                    commit_data = s00_axi_wdata;
                    commit_strb = s00_axi_wstrb;
                    wr_next     = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit     = 1'b1;
                    commit_idx = s00_axi_awaddr[ADDR_W-1:2];
                    wr_next    = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bvalid && s00_axi_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        commit_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            commit_sel[k] = commit && (commit_idx == IDX_W'(k));
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state        <= W_IDLE;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
            cfg_wr_pulse    <= '0;
            aw_idx_q        <= '0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= REG_RESET;
        end else begin
            wr_state        <= wr_next;
            s00_axi_awready <= (wr_next == W_IDLE) || (wr_next == W_HAVE_W);
            s00_axi_wready  <= (wr_next == W_IDLE) || (wr_next == W_HAVE_AW);
            s00_axi_bvalid  <= (wr_next == W_RESP);
            cfg_wr_pulse    <= commit_sel;
            if (aw_hs) aw_idx_q <= s00_axi_awaddr[ADDR_W-1:2];
            if (w_hs) begin
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end
            if (commit) s00_axi_bresp <= (|commit_sel) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_sel[k]) begin
                    regs[k] <= apply_wstrb(regs[k], commit_data, commit_strb);
                end
            end
        end
    end

    // Read mux sees pre-write register values on a same-edge collision.
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (s00_axi_araddr[ADDR_W-1:2] == IDX_W'(k)) begin
                rd_word = regs[k];
                rd_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_RESP;
            R_RESP:  if (s00_axi_rvalid && s00_axi_rready) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rd_state        <= R_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            rd_state        <= rd_next;
            s00_axi_arready <= (rd_next == R_IDLE);
            s00_axi_rvalid  <= (rd_next == R_RESP);
            if (ar_hs) begin
                s00_axi_rdata <= rd_word;
                s00_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_regs[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_fabcfg_axil_regfile.sv
// Directed and randomized AXI4-Lite traffic against a word-array model
// of the configuration registers.
module tb_fabcfg_axil_regfile;

    localparam int          NREGS = 4;
    localparam logic [31:0] RST_V = 32'h5A5A_0000;

    logic          clk = 1'b0;
    logic          areset;
    logic [4:0]    awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [127:0]  cfg_regs;
    logic [3:0]    cfg_wr_pulse;

    int total = 0;
    int bad   = 0;
    logic [31:0] m [NREGS];

    fabcfg_axil_regfile #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .NUM_REGS(NREGS),
        .REG_RESET(RST_V)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_areset(areset),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .cfg_regs(cfg_regs),
        .cfg_wr_pulse(cfg_wr_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] flat();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_start,
                             input int w_start, input int b_hold);
        bit aw_done, w_done, aw_t, w_t;
        int c, idx;
        logic [1:0] exp_resp;
        logic [3:0] exp_pulse;
        aw_done = 0; w_done = 0; c = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && c < 40) begin
            if (!aw_done && c >= aw_start) awvalid = 1'b1;
            if (!w_done && c >= w_start) wvalid = 1'b1;
            if (aw_done && !w_done) check("aw_held_awready", awready, 0);
            if (w_done && !aw_done) check("w_held_wready", wready, 0);
            aw_t = awvalid && awready;
            w_t  = wvalid && wready;
            @(negedge clk);
            if (aw_t) begin aw_done = 1; awvalid = 1'b0; end
            if (w_t) begin w_done = 1; wvalid = 1'b0; end
            c++;
        end
        check("w_handshake", aw_done && w_done, 1);
        idx = int'(addr[4:2]);
        if (idx < NREGS) begin
            exp_resp  = 2'b00;
            exp_pulse = 4'(1 << idx);
            for (int b = 0; b < 4; b++)
                if (strb[b]) m[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_resp  = 2'b10;
            exp_pulse = 4'b0;
        end
        check("b_valid", bvalid, 1);
        check("b_resp", bresp, exp_resp);
        check("wr_pulse", cfg_wr_pulse, exp_pulse);
        check("cfg_regs", cfg_regs, flat());
        for (int i = 0; i < b_hold; i++) begin
            @(negedge clk);
            check("b_hold_valid", bvalid, 1);
            check("b_hold_resp", bresp, exp_resp);
            check("b_hold_readies", {awready, wready}, 0);
            check("b_hold_pulse", cfg_wr_pulse, 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_done", bvalid, 0);
        check("b_done_pulse", cfg_wr_pulse, 0);
        check("b_done_readies", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int r_hold);
        int c, idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx = int'(addr[4:2]);
        exp_data = (idx < NREGS) ? m[idx] : 32'h0;
        exp_resp = (idx < NREGS) ? 2'b00 : 2'b10;
        araddr = addr; arvalid = 1'b1; c = 0;
        while (!arready && c < 20) begin @(negedge clk); c++; end
        check("ar_accept", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("r_valid", rvalid, 1);
        check("r_data", rdata, exp_data);
        check("r_resp", rresp, exp_resp);
        for (int i = 0; i < r_hold; i++) begin
            @(negedge clk);
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, exp_data);
            check("r_hold_arready", arready, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_done", rvalid, 0);
        check("r_done_arready", arready, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old2;
        int op;
        areset = 1'b1;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
        bready = 0; arvalid = 0; rready = 0;
        for (int k = 0; k < NREGS; k++) m[k] = RST_V;
        repeat (3) @(negedge clk);
        check("rst_readies", {awready, wready, arready}, 0);
        check("rst_valids", {bvalid, rvalid}, 0);
        check("rst_resp", {bresp, rresp}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_pulse", cfg_wr_pulse, 0);
        check("rst_regs", cfg_regs, flat());
        areset = 1'b0;
        @(negedge clk);
        check("post_rst_readies", {awready, wready, arready}, 3'b111);

        for (int k = 0; k < 4; k++)
            axi_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
        for (int k = 0; k < 4; k++) axi_read(5'(4 * k), 0);
        check("cfg_regs_1234", cfg_regs,
              128'h00000004_00000003_00000002_00000001);

        axi_write(5'h04, 32'hAABBCCDD, 4'b1111, 0, 0, 0);
        axi_write(5'h04, 32'h11223344, 4'b0101, 0, 0, 0);
        axi_read(5'h04, 0);
        check("strb_merge", cfg_regs[63:32], 32'hAA22CC44);
        axi_write(5'h04, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);

        axi_write(5'h08, 32'hCAFE0008, 4'hF, 0, 3, 0);
        axi_write(5'h0C, 32'hBEEF000C, 4'hF, 2, 0, 0);
        axi_read(5'h08, 0);
        axi_read(5'h0C, 0);

        axi_write(5'h00, 32'h0BAD0000, 4'hF, 0, 0, 5);
        axi_read(5'h00, 5);

        axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, 0);
        axi_read(5'h1C, 0);
        check("oor_rdata", rdata, 0);

        old2 = m[2];
        awaddr = 5'h08; wdata = 32'h600D0002; wstrb = 4'hF; araddr = 5'h08;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        m[2] = 32'h600D0002;
        check("coll_rvalid", rvalid, 1);
        check("coll_rdata_old", rdata, old2);
        check("coll_bvalid", bvalid, 1);
        check("coll_regs", cfg_regs, flat());
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        check("coll_done", {bvalid, rvalid}, 0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            if (op == 0)
                axi_read(5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
            else
                axi_write(5'($urandom_range(0, 31)), $urandom,
                          4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)));
        end

        awaddr = 5'h08; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        check("mid_aw_taken", {awready, wready}, 2'b01);
        areset = 1;
        @(negedge clk);
        for (int k = 0; k < NREGS; k++) m[k] = RST_V;
        check("mid_rst_readies", {awready, wready, arready}, 0);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_regs", cfg_regs, flat());
        areset = 0;
        @(negedge clk);
        check("mid_rst_readies_up", {awready, wready, arready}, 3'b111);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_b", bvalid, 0);
        end
        axi_read(5'h08, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
